// File: rtl/xnor_run_length_detector.sv
// xnor_run_length_detector
// Measures runs of consecutive equality matches coming from the XNOR stage
// and emits one run-length record per completed run through a one-entry
// registered output with backpressure. A one-cycle hit pulse marks the point
// where a run first reaches THRESH.
module xnor_run_length_detector #(
  parameter int WIDTH  = 8,
  parameter int THRESH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_eq,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_len,
  output logic             hit
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ZERO   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] THRESH_VAL = WIDTH'(THRESH);

  // Saturating increment: a counter at its ceiling stays there.
  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + WIDTH'(1);
    end
    return r;
  endfunction

  state_t           state_r;
  logic [WIDTH-1:0] run_cnt_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_len_r;
  logic             hit_r;

  logic             in_ready_s;
  logic             acc_s;
  logic             flush_s;
  logic             one_s;
  logic             zero_s;
  logic             term_s;
  logic             emit_s;
  logic             hit_s;
  logic [WIDTH-1:0] cnt_inc_s;
  logic [WIDTH-1:0] cnt_next_s;

  // Handshake, run-termination and hit decisions for the current cycle.
  always_comb begin
    // The output slot is free when empty or being drained this cycle.
    in_ready_s = rst_n & (~out_valid_r | out_ready);
    acc_s      = in_valid & in_ready_s;
    // A flush waits for a free output slot just like data does.
    flush_s    = flush & in_ready_s;
    one_s      = acc_s & in_eq;
    zero_s     = acc_s & ~in_eq;
    cnt_inc_s  = sat_inc(run_cnt_r);

    // The accepted bit is applied before any termination takes effect.
    if (one_s) begin
      cnt_next_s = cnt_inc_s;
    end else begin
      cnt_next_s = run_cnt_r;
    end

    term_s = zero_s | flush_s;

    // Only a non-empty run produces a record.
    emit_s = 1'b0;
    case (state_r)
      IDLE:    emit_s = term_s & one_s;
      RUN:     emit_s = term_s;
      default: emit_s = 1'b0;
    endcase

    // Count is monotonic within a run, so requiring the old count to differ
    // from THRESH keeps a saturated counter from retriggering.
    hit_s = one_s & (cnt_inc_s == THRESH_VAL) & (run_cnt_r != THRESH_VAL);
  end

  // Run counter, state, output record register and hit pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      run_cnt_r   <= CNT_ZERO;
      out_valid_r <= 1'b0;
      out_len_r   <= CNT_ZERO;
      hit_r       <= 1'b0;
    end else begin
      hit_r <= hit_s;

      if (emit_s) begin
        out_valid_r <= 1'b1;
        out_len_r   <= cnt_next_s;
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
        out_len_r   <= CNT_ZERO;
      end else begin
        out_valid_r <= out_valid_r;
        out_len_r   <= out_len_r;
      end

      if (term_s) begin
        run_cnt_r <= CNT_ZERO;
        state_r   <= IDLE;
      end else if (one_s) begin
        run_cnt_r <= cnt_inc_s;
        state_r   <= RUN;
      end else begin
        run_cnt_r <= run_cnt_r;
        state_r   <= state_r;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_len   = out_len_r;
  assign hit       = hit_r;

endmodule

// File: tb/tb_xnor_run_length_detector.sv
// Scoreboard bench for xnor_run_length_detector (WIDTH=4, THRESH=4).
// Directed steps carry hand-computed expected records and hit pulses; a
// separate monitor pops and compares them when the DUT presents them.
module tb_xnor_run_length_detector;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_eq = 1'b0;
  logic       flush = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_len;
  logic       hit;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rec_q[$];
  int hit_q[$];
  logic       prev_stall = 1'b0;
  logic [3:0] prev_len = 4'd0;

  xnor_run_length_detector #(.WIDTH(4), .THRESH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_eq(in_eq), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_len(out_len), .hit(hit)
  );

  always #5 clk = ~clk;

  // Edge counter used to time hit pulses.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: inputs and outputs are both stable at negedge+1.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (prev_stall) begin
        check("stall_valid", int'(out_valid), 1);
        check("stall_len", int'(out_len), int'(prev_len));
      end
      prev_stall = out_valid & ~out_ready;
      prev_len   = out_len;
      if (out_valid && out_ready) begin
        if (rec_q.size() == 0) check("rec_extra", int'(out_len), -1);
        else check("rec_len", int'(out_len), rec_q.pop_front());
      end
      if (hit) begin
        if (hit_q.size() == 0) check("hit_extra", cyc, -1);
        else check("hit_cycle", cyc, hit_q.pop_front());
      end
    end
  end

  // One directed step: drive for one edge, check in_ready, queue expectations.
  task automatic step(input logic v, input logic eq, input logic fl,
                      input logic ordy, input logic exp_rdy,
                      input int exp_len, input logic exp_hit);
    @(negedge clk);
    in_valid  = v;
    in_eq     = eq;
    flush     = fl;
    out_ready = ordy;
    if (exp_len != 0) rec_q.push_back(exp_len);
    if (exp_hit) hit_q.push_back(cyc + 1);
    #1;
    check("in_ready", int'(in_ready), int'(exp_rdy));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_len"}, int'(out_len), 0);
    check({tag, "_hit"}, int'(hit), 0);
  endtask

  initial begin
    // Reset then idle.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 0);
    check_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", int'(in_ready), 1);
    check_reset_vals("post_rst");

    // Basic run 1,1,1,1,1,0 -> hit on 4th, record 5.
    step(1, 1, 0, 1, 1, 0, 0);
    step(1, 1, 0, 1, 1, 0, 0);
    step(1, 1, 0, 1, 1, 0, 0);
    step(1, 1, 0, 1, 1, 0, 1);
    step(1, 1, 0, 1, 1, 0, 0);
    step(1, 0, 0, 1, 1, 5, 0);
    step(0, 0, 0, 1, 1, 0, 0);

    // Leading zeros and single-match runs: 0,0,1,0,1,0.
    step(1, 0, 0, 1, 1, 0, 0);
    step(1, 0, 0, 1, 1, 0, 0);
    step(1, 1, 0, 1, 1, 0, 0);
    step(1, 0, 0, 1, 1, 1, 0);
    step(1, 1, 0, 1, 1, 0, 0);
    step(1, 0, 0, 1, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0, 0);

    // Saturation: 20 ones then a zero -> 15, one hit.
    for (int i = 1; i <= 20; i++) step(1, 1, 0, 1, 1, 0, (i == 4));
    step(1, 0, 0, 1, 1, 15, 0);
    step(0, 0, 0, 1, 1, 0, 0);

    // Backpressure: 1,1,0 with consumer stalled.
    step(1, 1, 0, 0, 1, 0, 0);
    step(1, 1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 1, 2, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    // Release: record taken, held 1 accepted and starts a new run.
    step(1, 1, 0, 1, 1, 0, 0);
    step(1, 0, 0, 1, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0, 0);

    // Flush with an accepted 1 after 1,1,1 -> record 4 and hit.
    step(1, 1, 0, 1, 1, 0, 0);
    step(1, 1, 0, 1, 1, 0, 0);
    step(1, 1, 0, 1, 1, 0, 0);
    step(1, 1, 1, 1, 1, 4, 1);
    step(0, 0, 0, 1, 1, 0, 0);
    // Flush alone in idle does nothing.
    step(0, 0, 1, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);

    // Run 1,1 then reset: nothing emitted, the run is discarded.
    step(1, 1, 0, 1, 1, 0, 0);
    step(1, 1, 0, 1, 1, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", int'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset_vals("midrst");
    // A zero right after reset must not flush a stale run.
    step(1, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);

    repeat (2) @(negedge clk);
    #2;
    check("rec_q_left", rec_q.size(), 0);
    check("hit_q_left", hit_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xnor_run_length_detector.md
# xnor_run_length_detector

Downstream consumer of the bitwise XNOR equality stage. Each cycle it takes one equality bit (1 = operands matched, 0 = mismatch) over a valid/ready handshake and measures runs of consecutive matches. It emits one run-length record per completed run through a one-entry registered output with backpressure. It also pulses `hit` when a run first reaches a programmable threshold.

## Interface
Parameters:
- `WIDTH`, default 8: run-length counter and `out_len` width; maximum count is 2^WIDTH-1.
- `THRESH`, default 4: run length that fires `hit`; legal range 1..2^WIDTH-1.

Ports:
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `in_valid`  input  1  `in_eq` is valid this cycle.
- `in_ready`  output  1  the block accepts input this cycle.
- `in_eq`  input  1  equality bit from the XNOR stage.
- `flush`  input  1  single-cycle request to terminate the current run.
- `out_valid`  output  1  `out_len` holds a completed run.
- `out_ready`  input  1  the consumer takes the record.
- `out_len`  output  WIDTH  length of the completed run.
- `hit`  output  1  one-cycle pulse when the current run length reaches THRESH.

## Operation
- Accept condition: `acc = in_valid & in_ready`.
- `in_ready` is combinational: `rst_n & (~out_valid | out_ready)`.
- State machine, two states:
  - IDLE: `run_cnt == 0`.
  - RUN: `run_cnt > 0`.
- `acc` with `in_eq=1`:
  - `run_cnt <= sat(run_cnt+1)`; next state is RUN.
  - The counter saturates at 2^WIDTH-1 and stays there.
- `acc` with `in_eq=0`:
  - From RUN: load `out_len <= run_cnt`, set `out_valid <= 1`, clear `run_cnt`, go to IDLE.
  - From IDLE: no effect; no zero-length records are ever emitted.
- `hit`:
  - Asserted for exactly one cycle after an accepted 1 whose post-increment count equals THRESH.
  - Fires at most once per run. A saturated counter does not retrigger it.
- `flush`:
  - Honoured only when `in_ready=1`; the requester holds it until then.
  - Alone in RUN: behaves as an accepted 0.
  - In IDLE: no effect.
  - With `acc` in the same cycle: the input bit is applied first, then the run terminates. For example, in RUN with `run_cnt=3`, `acc` with `in_eq=1` plus `flush` emits `out_len=4`.
  - Flush plus an accepted 0 emits a single record.
- Output register:
  - `out_valid` and `out_len` are held stable while `out_valid & ~out_ready`.
  - The register clears when `out_ready` is high and no new record loads that cycle.
  - A new record may load in the same cycle the old one is taken (back-to-back throughput).
- Reset (`rst_n=0` at an edge): `run_cnt=0`, state IDLE, `out_valid=0`, `out_len=0`, `hit=0`. `in_ready` is 0 while `rst_n` is low.
- Reset mid-run or with a pending record discards both; no record is emitted.

## Timing
- Input-to-record latency is 1 cycle. `out_valid` rises on the edge that accepted the terminating 0 or flush.
- `hit` rises on the edge that accepted the THRESH-th consecutive 1 and falls on the next edge.
- Throughput is one input per cycle while the consumer holds `out_ready=1`.
- When `out_valid=1` and `out_ready=0`, `in_ready` drops in the same cycle and no input is lost.
- Runs of 1s continue to count while the output is stalled? No: with `in_ready=0` no input is accepted, so stall freezes counting.
- No combinational path from `in_valid` or `in_eq` to any output. The only combinational path is `out_ready` to `in_ready`.

## Test plan
Parameters for all cases: WIDTH=4, THRESH=4.
- Reset then idle: hold `rst_n=0` for 2 cycles, then release → `out_valid=0`, `out_len=0`, `hit=0`; `in_ready=1` on the first cycle after release.
- Basic run: with `out_ready=1`, stream 1,1,1,1,1,0 → `hit` pulses one cycle after the 4th accepted 1; `out_len=5` with `out_valid` for one cycle after the 0.
- Leading zeros and single-match runs: stream 0,0,1,0,1,0 → exactly two records with `out_len=1` each; `hit` never asserts.
- Saturation: 20 consecutive 1s then a 0 → `out_len=15`; `hit` pulsed exactly once.
- Backpressure:
  - Run 1,1,0 with `out_ready=0` → `out_len=2` held.
  - `in_ready=0` for 3 cycles while `in_valid` and `in_eq=1` are held.
  - Raise `out_ready` → record taken; the held 1 starts a new run.
  - Then 0 → `out_len=1`.
- Flush and reset cases:
  - 1,1,1 followed by `flush` together with an accepted 1 → `out_len=4`, `hit` pulses.
  - A separate run 1,1 followed by `rst_n=0` → no record is emitted; the block returns to reset values.
